// File: rtl/pipe_pkg.sv
// Shared encodings for the 5-stage pipeline: writeback source, next-PC op,
// EX forwarding select and the hazard controller state.
package pipe_pkg;

  localparam logic [1:0] WSEL_ALU = 2'd0;
  localparam logic [1:0] WSEL_RAM = 2'd1;
  localparam logic [1:0] WSEL_PC4 = 2'd2;
  localparam logic [1:0] WSEL_EXT = 2'd3;

  localparam logic [1:0] NPC_PC4  = 2'd0;
  localparam logic [1:0] NPC_BR   = 2'd1;
  localparam logic [1:0] NPC_JMP  = 2'd2;
  localparam logic [1:0] NPC_JALR = 2'd3;

  localparam logic [1:0] FWD_RF   = 2'd0;
  localparam logic [1:0] FWD_EX   = 2'd1;
  localparam logic [1:0] FWD_MEM  = 2'd2;
  localparam logic [1:0] FWD_WB   = 2'd3;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERR      = 2'd2
  } state_t;

endpackage

// File: rtl/fwd_unit.sv
// Combinational EX operand source select for one register source; zero latency.
// Also flags a MEM-stage load match, whose data is not yet forwardable.
module fwd_unit
  import pipe_pkg::*;
(
  input  logic [4:0] src,
  input  logic       re,
  input  logic [4:0] ex_wR,
  input  logic       ex_rf_we,
  input  logic       ex_load,
  input  logic [4:0] mem_wR,
  input  logic       mem_rf_we,
  input  logic [1:0] mem_rf_wsel,
  input  logic [4:0] wb_wR,
  input  logic       wb_rf_we,
  output logic [1:0] sel,
  output logic       mem_load_hit
);

  always_comb begin
    sel          = FWD_RF;
    mem_load_hit = 1'b0;
    if (src != 5'd0 && re) begin
      if (ex_rf_we && ex_wR == src && !ex_load) begin
        sel = FWD_EX;
      end else if (mem_rf_we && mem_wR == src) begin
        // A MEM load shadows any older WB value for the same register.
        if (mem_rf_wsel != WSEL_RAM) sel = FWD_MEM;
        else                         mem_load_hit = 1'b1;
      end else if (wb_rf_we && wb_wR == src) begin
        sel = FWD_WB;
      end
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: combinational stall/flush/forward controls, RAM-wait FSM with watchdog.
// Optional HAZARD_PERF_EN adds load-use, RAM-wait and flush event counters.
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int TIMEOUT_W   = 8,
  parameter int MEM_TIMEOUT = 200
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  id_rR1,
  input  logic [4:0]  id_rR2,
  input  logic        id_re1,
  input  logic        id_re2,
  input  logic [4:0]  ex_wR,
  input  logic        ex_rf_we,
  input  logic [1:0]  ex_rf_wsel,
  input  logic [4:0]  mem_wR,
  input  logic        mem_rf_we,
  input  logic [1:0]  mem_rf_wsel,
  input  logic [4:0]  wb_wR,
  input  logic        wb_rf_we,
  input  logic [1:0]  mem_npc_op,
  input  logic        mem_comp,
  input  logic        mem_access,
  input  logic        dram_ready,
  output logic        pc_stall,
  output logic        ifid_stall,
  output logic        ifid_flush,
  output logic        idex_stall,
  output logic        idex_flush,
  output logic        exmem_stall,
  output logic        exmem_flush,
  output logic        memwb_flush,
  output logic [1:0]  fwd_a,
  output logic [1:0]  fwd_b,
`ifdef HAZARD_PERF_EN
  output logic [31:0] lu_stall_cnt,
  output logic [31:0] mem_wait_cnt,
  output logic [31:0] flush_cnt,
`endif
  output logic        dram_err
);

  state_t               state;
  logic [TIMEOUT_W-1:0] wdog;
  logic                 ex_load, br_taken, ex_lu, hit_a, hit_b;
  logic [1:0]           sel_a, sel_b;
  logic                 ram_hold, stall_all, br_flush, lu_stall;

  assign ex_load  = ex_rf_we && (ex_rf_wsel == WSEL_RAM);
  assign br_taken = (mem_npc_op == NPC_JMP) || (mem_npc_op == NPC_JALR) ||
                    ((mem_npc_op == NPC_BR) && mem_comp);

  fwd_unit u_fwd_a (
    .src(id_rR1), .re(id_re1), .ex_wR(ex_wR), .ex_rf_we(ex_rf_we), .ex_load(ex_load),
    .mem_wR(mem_wR), .mem_rf_we(mem_rf_we), .mem_rf_wsel(mem_rf_wsel),
    .wb_wR(wb_wR), .wb_rf_we(wb_rf_we), .sel(sel_a), .mem_load_hit(hit_a)
  );

  fwd_unit u_fwd_b (
    .src(id_rR2), .re(id_re2), .ex_wR(ex_wR), .ex_rf_we(ex_rf_we), .ex_load(ex_load),
    .mem_wR(mem_wR), .mem_rf_we(mem_rf_we), .mem_rf_wsel(mem_rf_wsel),
    .wb_wR(wb_wR), .wb_rf_we(wb_rf_we), .sel(sel_b), .mem_load_hit(hit_b)
  );

  assign ex_lu = ex_load && (ex_wR != 5'd0) &&
                 ((id_re1 && id_rR1 == ex_wR) || (id_re2 && id_rR2 == ex_wR));

  // The RAM wait outranks the branch flush, which outranks load-use; a flush
  // held back by the wait surfaces on the dram_ready release cycle.
  always_comb begin
    ram_hold  = (state == ERR) ||
                ((state == MEM_WAIT) && !dram_ready) ||
                ((state == RUN) && mem_access && !dram_ready);
    stall_all = rst_n && ram_hold;
    br_flush  = rst_n && !ram_hold && br_taken;
    lu_stall  = rst_n && !ram_hold && !br_taken && (ex_lu || hit_a || hit_b);
  end

  assign pc_stall    = stall_all || lu_stall;
  assign ifid_stall  = stall_all || lu_stall;
  assign ifid_flush  = br_flush;
  assign idex_stall  = stall_all;
  assign idex_flush  = br_flush || lu_stall;
  assign exmem_stall = stall_all;
  assign exmem_flush = br_flush;
  // Keeps the frozen MEM instruction from writing back repeatedly while held.
  assign memwb_flush = stall_all;
  assign fwd_a       = rst_n ? sel_a : FWD_RF;
  assign fwd_b       = rst_n ? sel_b : FWD_RF;
  assign dram_err    = (state == ERR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
      wdog  <= '0;
    end else begin
      case (state)
        RUN: begin
          if (mem_access && !dram_ready) begin
            state <= MEM_WAIT;
            wdog  <= '0;
          end
        end
        MEM_WAIT: begin
          if (dram_ready) begin
            state <= RUN;
          end else begin
            wdog <= wdog + 1'b1;
            if (wdog == TIMEOUT_W'(MEM_TIMEOUT - 1)) state <= ERR;
          end
        end
        default: state <= ERR;
      endcase
    end
  end

`ifdef HAZARD_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lu_stall_cnt <= '0;
      mem_wait_cnt <= '0;
      flush_cnt    <= '0;
    end else begin
      if (lu_stall)           lu_stall_cnt <= lu_stall_cnt + 32'd1;
      if (state == MEM_WAIT)  mem_wait_cnt <= mem_wait_cnt + 32'd1;
      if (br_flush)           flush_cnt    <= flush_cnt + 32'd1;
    end
  end
`endif

endmodule
